// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int INSTR_ALIGN = 4;

  // One prefetch buffer entry as seen by the decoder at the default widths
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_XLEN-1:0]   instr;
  } fetch_entry_t;

  // Pointer width with one extra wrap bit so full and empty are distinguishable
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers and flush
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [PTR_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                   (wptr_q[IDX_W] != rptr_q[IDX_W]);
  assign head_o  = mem_q[rptr_q[IDX_W-1:0]];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer next-state: flush wins over any push or pop in the same cycle
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[IDX_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch with prefetch buffer and redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int                PTR_W     = ptr_width(DEPTH);
  localparam int                ENTRY_W   = ADDR_W + XLEN;
  localparam logic [PTR_W:0]    DEPTH_EXT = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INSTR_ALIGN);
  localparam logic [ADDR_W-1:0] PC_MASK   = ~ADDR_W'(INSTR_ALIGN - 1);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]   outstanding_q, outstanding_d;
  logic [PTR_W-1:0]   drop_q, drop_d;

  logic [PTR_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] fifo_head;

  logic               credit_ok;
  logic               issue;
  logic               rsp_accept;
  logic               rsp_keep;
  logic               pop;
  logic [ADDR_W-1:0]  redirect_aligned;

  // Every issued request reserves a buffer slot, so a response always fits
  assign credit_ok     = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_EXT;
  assign mem_req_valid = reset & ce & ~redirect_valid & credit_ok;
  assign mem_req_addr  = fetch_pc_q;
  assign issue         = mem_req_valid & mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp_accept = mem_rsp_valid & (outstanding_q != '0);
  assign rsp_keep   = rsp_accept & (drop_q == '0) & ~redirect_valid;

  assign instr_valid = ce & ~fifo_empty;
  assign pop         = instr_valid & instr_ready & ~redirect_valid;
  assign instr_pc    = fifo_empty ? '0 : fifo_head[ENTRY_W-1:XLEN];
  assign instr_data  = fifo_empty ? '0 : fifo_head[XLEN-1:0];

  assign redirect_aligned = redirect_pc & PC_MASK;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i ({resp_pc_q, mem_rsp_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Outstanding counter: issue and response in the same cycle cancel out
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !rsp_accept) begin
      outstanding_d = outstanding_q + PTR_W'(1);
    end else if (!issue && rsp_accept) begin
      outstanding_d = outstanding_q - PTR_W'(1);
    end
  end

  // Drop counter: a redirect marks everything still in flight as stale
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = rsp_accept ? (outstanding_q - PTR_W'(1)) : outstanding_q;
    end else if (rsp_accept && (drop_q != '0)) begin
      drop_d = drop_q - PTR_W'(1);
    end
  end

  // PC tracking for requests and for tagging kept responses
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
    end else begin
      if (issue)    fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_keep) resp_pc_d  = resp_pc_q + PC_STEP;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rsp_valid && (outstanding_q == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_keep && fifo_full));

endmodule
